// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, FSM state encodings and access legality check
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_RESP = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   // funct3[1:0] gives the size for every legal code: 00 byte, 01 half, 10 word
   function automatic logic bad_access(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic inv, mis;
      inv = we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
      mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
      return inv || mis;
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: extracts the addressed byte/halfword from a bus word and extends it
module load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] val
);

   logic [31:0] sh;
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      sh  = rdata >> {off, 3'b000};
      b   = sh[7:0];
      h   = off[1] ? rdata[31:16] : rdata[15:0];
      val = funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_BU ? {24'b0, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_HU ? {16'b0, h} : rdata;
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store over a valid/ready bus, stalling the core until done
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              done,
   output logic              err,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_wstrb,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;

   logic [2:0]    state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [31:0]   rdata_q, ld_val, wd_lane;
   logic [3:0]    strb;
   logic          timeout;

   load_align u_align (
      .rdata  (bus_rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .val    (ld_val)
   );

   assign wd_lane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                    funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
   assign strb    = !mem_we                ? 4'b0000 :
                    funct3[1:0] == 2'b00   ? 4'b0001 << addr[1:0] :
                    funct3[1:0] == 2'b01   ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // stall is gated by rst so every output reads 0 while reset is held
   assign bus_valid = state_q == S_REQ;
   assign done      = state_q == S_DONE || state_q == S_ERR;
   assign err       = state_q == S_ERR;
   assign rdata     = err ? 32'b0 : rdata_q;
   assign stall     = rst && mem_req && !done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         rdata_q   <= '0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (mem_req) begin
               if (bad_access(mem_we, funct3, addr[1:0])) state_q <= S_ERR;
               else begin
                  state_q   <= S_REQ;
                  cnt_q     <= '0;
                  f3_q      <= funct3;
                  off_q     <= addr[1:0];
                  bus_we    <= mem_we;
                  bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  bus_wdata <= wd_lane;
                  bus_wstrb <= strb;
               end
            end
            S_REQ: begin
               cnt_q <= cnt_q + 1'b1;
               if (timeout) state_q <= S_ERR;
               else if (bus_ready) state_q <= bus_we ? S_DONE : S_RESP;
            end
            S_RESP: begin
               cnt_q <= cnt_q + 1'b1;
               if (timeout) state_q <= S_ERR;
               else if (bus_rvalid) begin
                  rdata_q <= ld_val;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus reset/timeout sequences for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0, rst = 1'b0;
   logic        mem_req = 1'b0, mem_we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        stall, done, err, bus_valid, bus_we;
   logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
   logic [3:0]  bus_wstrb;

   int total = 0, bad = 0;

   load_store_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .err(err),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      int          dly;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wd, e_rd;
      logic        e_err;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input int idx);
      int cyc, rc, lat;
      bit seen, got;
      mem_req = 1'b1; mem_we = v.we; funct3 = v.f3; addr = v.a; wdata = v.wd;
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      cyc = 0; rc = 0; seen = 0; got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1;
         else begin
            if (cyc == 1) chk($sformatf("v%0d_stall_busy", idx), 32'(stall), 32'd1);
            bus_ready = 1'b0; bus_rvalid = 1'b0;
            if (bus_valid) begin
               if (!seen) begin
                  chk($sformatf("v%0d_bus_addr", idx), bus_addr, v.e_addr);
                  chk($sformatf("v%0d_bus_wstrb", idx), 32'(bus_wstrb), 32'(v.e_strb));
                  chk($sformatf("v%0d_bus_we", idx), 32'(bus_we), 32'(v.we));
                  if (v.we) chk($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.e_wd);
               end
               seen = 1;
               bus_ready = 1'b1;
            end else if (seen) begin
               if (rc == v.dly) begin
                  bus_rvalid = 1'b1;
                  bus_rdata = v.rd;
               end
               rc++;
            end
         end
      end
      lat = v.e_err ? 1 : v.we ? 2 : 3 + v.dly;
      chk($sformatf("v%0d_done_seen", idx), 32'(got), 32'd1);
      if (got) begin
         chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(lat));
         chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.e_err));
         chk($sformatf("v%0d_stall_done", idx), 32'(stall), 32'd0);
         chk($sformatf("v%0d_bus_used", idx), 32'(seen), 32'(!v.e_err));
         if (!v.we || v.e_err) chk($sformatf("v%0d_rdata", idx), rdata, v.e_rd);
      end
      bus_ready = 1'b0; bus_rvalid = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
   endtask

   initial begin
      int vcount;
      bit got;
      //          we    f3      addr          wdata         bus_rdata     dly e_addr        strb     e_wdata       e_rdata       err
      vt[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0};
      vt[1]  = '{1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,        0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0};
      vt[2]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0,        0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0};
      vt[3]  = '{1'b1, 3'b000, 32'h0000_0200, 32'h0000_0011, 32'h0,        0, 32'h0000_0200, 4'b0001, 32'h1111_1111, 32'h0,        1'b0};
      vt[4]  = '{1'b0, 3'b000, 32'h0000_0302, 32'h0,         32'h12F0_3456, 3, 32'h0000_0300, 4'b0000, 32'h0,        32'hFFFF_FFF0, 1'b0};
      vt[5]  = '{1'b0, 3'b100, 32'h0000_0302, 32'h0,         32'h12F0_3456, 1, 32'h0000_0300, 4'b0000, 32'h0,        32'h0000_00F0, 1'b0};
      vt[6]  = '{1'b0, 3'b101, 32'h0000_0302, 32'h0,         32'h12F0_3456, 0, 32'h0000_0300, 4'b0000, 32'h0,        32'h0000_12F0, 1'b0};
      vt[7]  = '{1'b0, 3'b001, 32'h0000_0300, 32'h0,         32'h0000_8001, 2, 32'h0000_0300, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0};
      vt[8]  = '{1'b0, 3'b000, 32'h0000_0301, 32'h0,         32'h0000_7F00, 0, 32'h0000_0300, 4'b0000, 32'h0,        32'h0000_007F, 1'b0};
      vt[9]  = '{1'b0, 3'b010, 32'h0000_0304, 32'h0,         32'hCAFE_F00D, 0, 32'h0000_0304, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0};
      vt[10] = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
      vt[11] = '{1'b0, 3'b001, 32'h0000_0301, 32'h0,         32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
      vt[12] = '{1'b1, 3'b100, 32'h0000_0300, 32'h0000_0055, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
      vt[13] = '{1'b0, 3'b011, 32'h0000_0300, 32'h0,         32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};

      // reset held with a live request: everything must read 0
      mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      mem_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) run(vt[i], i);

      // timeout: ready never comes
      mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h400;
      vcount = 0; got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (done) got = 1;
         else if (bus_valid) vcount++;
      end
      chk("to_done_seen", 32'(got), 32'd1);
      chk("to_req_cycles", 32'(vcount), 32'd16);
      chk("to_err", 32'(err), 32'd1);
      chk("to_bus_valid", 32'(bus_valid), 32'd0);
      chk("to_rdata", rdata, 32'd0);
      mem_req = 1'b0;
      @(negedge clk);
      chk("to_after_valid", 32'(bus_valid), 32'd0);
      chk("to_after_done", 32'(done), 32'd0);

      // async reset while in REQ
      mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h500;
      @(negedge clk);
      chk("rq_valid_before", 32'(bus_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rq_valid_after", 32'(bus_valid), 32'd0);
      chk("rq_stall_after", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b1; mem_req = 1'b0;
      @(negedge clk);

      // async reset while in RESP
      mem_req = 1'b1;
      @(negedge clk);
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      chk("rs_in_resp_valid", 32'(bus_valid), 32'd0);
      chk("rs_in_resp_stall", 32'(stall), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rs_valid_after", 32'(bus_valid), 32'd0);
      chk("rs_stall_after", 32'(stall), 32'd0);
      chk("rs_done_after", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b1; mem_req = 1'b0;
      @(negedge clk);
      chk("rs_idle_done", 32'(done), 32'd0);
      run(vt[9], 99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit directly downstream of the core's ALU and register read ports.
- Consumes ALUResult (address), RD2 (store data) and funct3. Drives a valid/ready data bus with byte strobes.
- Returns the aligned, extended load data to the result mux.
- Holds the core with a stall until the access completes. This replaces the zero-latency data memory path.

Parameters:
- TIMEOUT_CYCLES, 16: bus cycles allowed per access before an error completion; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- mem_req  input  1  instruction is a load/store; held until done
- mem_we  input  1  1 = store, 0 = load
- funct3  input  3  access size/sign (RV32I encoding)
- addr  input  ADDR_W  byte address (ALUResult)
- wdata  input  32  store data (RD2)
- rdata  output  32  extended load result; valid when done=1
- stall  output  1  freeze PC/regfile write
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse, coincident with done
- bus_valid  output  1  request valid
- bus_ready  input  1  request accepted
- bus_we  output  1  write request
- bus_addr  output  ADDR_W  word-aligned address, addr with [1:0]=0
- bus_wdata  output  32  lane-replicated store data
- bus_wstrb  output  4  byte enables; 0000 on reads
- bus_rvalid  input  1  read data valid
- bus_rdata  input  32  read word

Behaviour:
- Reset: single clock clk; rst is asynchronous, active-low. While rst=0: state=IDLE, all outputs 0, timeout counter 0. Asserting rst mid-access drops bus_valid immediately, with no completion pulse.
- States: IDLE, REQ, RESP, DONE, ERR.
- IDLE, mem_req=1, invalid or misaligned access: go to ERR with no bus activity.
  - Invalid funct3: 011, 110, 111; for stores, any funct3 above 010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE, mem_req=1, otherwise: latch the access, then go to REQ.
  - Latched: mem_we, funct3, addr[1:0], bus_addr, bus_wdata, bus_wstrb.
- Store lanes:
  - SB: byte replicated to all four lanes, wstrb = 1 << addr[1:0].
  - SH: halfword replicated, wstrb = 0011 or 1100 by addr[1].
  - SW: wstrb = 1111.
- REQ: bus_valid=1. bus_addr/bus_we/bus_wdata/bus_wstrb stay stable until bus_ready. On bus_valid && bus_ready: store goes to DONE, load goes to RESP.
- RESP: wait for bus_rvalid, then capture the extracted and extended bus_rdata into the rdata register and go to DONE. bus_rvalid seen in REQ is ignored.
- Load extraction:
  - LB/LBU: byte at addr[1:0].
  - LH/LHU: halfword at addr[1].
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- DONE: done=1 for one cycle, then IDLE. rdata holds its value until the next load completes.
- ERR: done=1, err=1, rdata=0 for one cycle, then IDLE. Stores are suppressed.
- Timeout: counter runs in REQ and RESP and resets on entry to REQ. When it reaches TIMEOUT_CYCLES-1 without the awaited event, go to ERR and drop bus_valid. Bus events arriving in that same cycle are ignored.
- stall is combinational: stall = mem_req && !(state==DONE || state==ERR). The core therefore retires the instruction in the DONE/ERR cycle.
- Back-to-back: a new mem_req is sampled only in IDLE. Minimum occupancy is 3 cycles per store and 4 per load with ready/rvalid at 1 wait.
- mem_req dropping outside IDLE (e.g. flush) does not abort the bus transaction; it completes silently.

Decomposition:
- Shared include lsu_defs.vh holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state encodings.
- One natural combinational sub-module, load_align:
  - Inputs: bus_rdata, addr[1:0], funct3.
  - Output: the extended 32-bit value.
  - Verified standalone.

Test Plan:
- SW, addr=0x100, wdata=0xDEADBEEF, bus_ready=1 in first REQ cycle -> bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, done pulses 2 cycles after req, stall low in that cycle.
- SB, addr=0x203, wdata=0x000000A5 -> bus_addr=0x200, wstrb=1000, bus_wdata=0xA5A5A5A5.
- LB, addr=0x302, bus_rdata=0x12F03456, rvalid 3 cycles late -> rdata=0xFFFFFFF0. LBU at the same address -> 0x000000F0. LHU at addr 0x302 -> 0x000012F0.
- LW, addr=0x101 -> ERR next cycle: err=1, done=1, bus_valid never asserted, rdata=0.
- LW with bus_ready stuck 0, TIMEOUT_CYCLES=16 -> err pulse after 16 REQ cycles, bus_valid deasserted afterward.
- rst driven low while in RESP, between clock edges -> bus_valid, stall, done=0 immediately. After release, a new LW completes normally.
